if_pc_gen: RTL

IF_PC_GEN -- requirements
Module: if_pc_gen

---
 rtl/if_pc_gen.sv | 73 +++++++
 1 files changed

// File: rtl/if_pc_gen.sv
// if_pc_gen: sequential fetch-address generator with a small address buffer, redirect flush and misalignment flag
//   clk, reset_n          : clock, asynchronous active-low reset
//   en                    : fetch enable (stops new pushes only)
//   redirect_valid/_addr  : single-cycle redirect request and target
//   tx_valid/tx_ready     : head-entry handshake toward the consumer
//   instruction_addr      : head-entry address (0 while empty)
//   count                 : buffer occupancy
//   misalign_err          : one-cycle pulse after a misaligned redirect target
module if_pc_gen #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                STEP      = 4,
    parameter int                DEPTH     = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_addr,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [ADDR_W-1:0]          instruction_addr,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       misalign_err
);
    localparam int                PW   = $clog2(DEPTH);
    localparam int                CW   = $clog2(DEPTH+1);
    localparam logic [ADDR_W-1:0] MASK = ADDR_W'(STEP - 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic              mis_q, mis_d;
    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic              pop, push;

    assign tx_valid         = count_q != '0;
    assign pop              = tx_valid && tx_ready;
    // a full buffer may still push when the head leaves on the same edge
    assign push             = en && !redirect_valid && (count_q != CW'(DEPTH) || pop);
    assign count            = count_q;
    assign misalign_err     = mis_q;
    assign instruction_addr = tx_valid ? mem_q[rd_q] : '0;

    always_comb begin
        pc_d    = redirect_valid ? (redirect_addr & ~MASK) : push ? pc_q + ADDR_W'(STEP) : pc_q;
        count_d = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
        // a flush just moves the read pointer onto the write pointer
        rd_d    = redirect_valid ? wr_q : rd_q + PW'(pop);
        wr_d    = wr_q + PW'(push);
        mis_d   = redirect_valid && (redirect_addr & MASK) != '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_VEC;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            mis_q   <= mis_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= pc_q;
    end
endmodule
